// File: rtl/script_sequencer.sv
// script_sequencer: fetches 16-bit script instructions from a synchronous ROM,
// executes internal control ops (nop/call/return/halt) directly and hands
// everything else to one of N_UNITS execution units. It supports free-run and
// single-step modes, unit-driven branches, a call stack, a per-instruction
// timeout, and sticky HALT/ERROR states.
//
// Unit handshake: unit_start[i] is a one-cycle pulse in DISPATCH, and
// unit_instr is stable from that cycle until the next LATCH. From the cycle
// after the pulse, the sequencer samples only unit_done[i] on every rising
// edge. The cycle in which it sees unit_done[i]=1 completes the instruction.
// unit_jump[i] and the unit's unit_target slice are sampled in that same
// cycle. A done that arrives together with the timeout still completes.
module script_sequencer #(
  parameter int          PC_W        = 8,
  parameter int          INSTR_W     = 16,
  parameter int          PC_STEP     = 2,
  parameter int          N_UNITS     = 4,
  parameter int          STACK_DEPTH = 4,
  parameter logic [23:0] TIMEOUT     = 24'd10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_mode,
  input  logic                     step,
  output logic [PC_W-1:0]          mem_addr,
  input  logic [INSTR_W-1:0]       mem_data,
  output logic [N_UNITS-1:0]       unit_start,
  output logic [INSTR_W-1:0]       unit_instr,
  input  logic [N_UNITS-1:0]       unit_done,
  input  logic [N_UNITS-1:0]       unit_jump,
  input  logic [N_UNITS*PC_W-1:0]  unit_target,
  output logic [PC_W-1:0]          pc,
  output logic [2:0]               state,
  output logic                     halted,
  output logic [2:0]               error,
  output logic [15:0]              retired
);

  localparam logic [2:0] S_GATE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_LATCH    = 3'd2;
  localparam logic [2:0] S_DISPATCH = 3'd3;
  localparam logic [2:0] S_EXEC     = 3'd4;
  localparam logic [2:0] S_HALT     = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  localparam logic [2:0] E_NONE      = 3'd0;
  localparam logic [2:0] E_ILLEGAL   = 3'd1;
  localparam logic [2:0] E_OVERFLOW  = 3'd2;
  localparam logic [2:0] E_UNDERFLOW = 3'd3;
  localparam logic [2:0] E_TIMEOUT   = 3'd4;

  localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [PC_W-1:0] PC_INC  = PC_W'(PC_STEP);

  // The instruction register doubles as the unit_instr output.
  logic [INSTR_W-1:0]  ir;
  logic [N_UNITS-1:0]  unit_sel;
  logic [N_UNITS-1:0]  dec_sel;
  logic [SP_W-1:0]     sp;
  logic [23:0]         tmo_cnt;
  logic [PC_W-1:0]     pc_seq;
  logic [PC_W-1:0]     jump_tgt;
  logic                done_hit;
  logic                jump_hit;
  logic                is_ctrl;
  logic [1:0]          func;
  // Entry STACK_DEPTH is never written; it keeps the index width equal to sp.
  logic [PC_W-1:0]     stack_mem [STACK_DEPTH+1];

  assign mem_addr   = pc;
  assign unit_instr = ir;
  assign pc_seq     = pc + PC_INC;
  assign is_ctrl    = (ir[2:0] == 3'd7);
  assign func       = ir[4:3];
  assign done_hit   = |(unit_done & unit_sel);
  assign jump_hit   = |(unit_jump & unit_sel);

  // Decode ROM data into a one-hot unit select. Opcodes outside the unit range give zero.
  always_comb begin
    dec_sel  = '0;
    jump_tgt = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      dec_sel[i] = (mem_data[2:0] == 3'(i));
      if (unit_sel[i]) jump_tgt = unit_target[i*PC_W +: PC_W];
    end
  end

  // Main FSM: fetch, decode and dispatch, wait for completion, then retire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_GATE;
      pc         <= '0;
      ir         <= '0;
      unit_start <= '0;
      unit_sel   <= '0;
      sp         <= '0;
      tmo_cnt    <= '0;
      halted     <= 1'b0;
      error      <= E_NONE;
      retired    <= '0;
    end else begin
      unit_start <= '0;
      case (state)
        S_GATE: begin
          if (run_mode || step) state <= S_FETCH;
        end
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          // The start pulse is registered here so that it is visible during DISPATCH.
          ir         <= mem_data;
          unit_sel   <= dec_sel;
          unit_start <= dec_sel;
          state      <= S_DISPATCH;
        end
        S_DISPATCH: begin
          if (|unit_sel) begin
            tmo_cnt <= '0;
            state   <= S_EXEC;
          end else if (is_ctrl) begin
            case (func)
              2'b00: begin
                pc      <= pc_seq;
                retired <= retired + 16'd1;
                state   <= S_GATE;
              end
              2'b01: begin
                if (sp == SP_FULL) begin
                  error <= E_OVERFLOW;
                  state <= S_ERROR;
                end else begin
                  sp      <= sp + SP_ONE;
                  pc      <= ir[8 +: PC_W];
                  retired <= retired + 16'd1;
                  state   <= S_GATE;
                end
              end
              2'b10: begin
                if (sp == '0) begin
                  error <= E_UNDERFLOW;
                  state <= S_ERROR;
                end else begin
                  sp      <= sp - SP_ONE;
                  pc      <= stack_mem[sp - SP_ONE];
                  retired <= retired + 16'd1;
                  state   <= S_GATE;
                end
              end
              default: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
            endcase
          end else begin
            error <= E_ILLEGAL;
            state <= S_ERROR;
          end
        end
        S_EXEC: begin
          if (done_hit) begin
            pc      <= jump_hit ? jump_tgt : pc_seq;
            retired <= retired + 16'd1;
            state   <= S_GATE;
          end else if (tmo_cnt == TIMEOUT - 24'd1) begin
            error <= E_TIMEOUT;
            state <= S_ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        default: begin
          // HALT and ERROR are terminal; only rst leaves them.
        end
      endcase
    end
  end

  // Write the return address on a successful call; the storage needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_DISPATCH && is_ctrl && func == 2'b01 && sp != SP_FULL)
      stack_mem[sp] <= pc_seq;
  end

endmodule

// File: doc/script_sequencer.md
# script_sequencer

Parametrised script interpreter for the traveler control path. It fetches instructions from the script ROM and decodes the opcode. It dispatches each instruction to one of `N_UNITS` execution units (action, jump, wait, game-state, …) over a start/done handshake. Beyond the single-step PC of the previous generation it adds:
- free-running and step modes,
- unit-driven branching,
- a hardware call/return stack,
- per-instruction timeout, error reporting and halt.

## Interface
Parameters:
- `PC_W` = 8: program-counter / ROM address width.
- `INSTR_W` = 16: instruction width. Field layout: [15:8] i_num, [7:5] i_sign, [4:3] func, [2:0] op_code.
- `PC_STEP` = 2: PC increment per sequential instruction.
- `N_UNITS` = 4: number of execution units, 1..7. Units occupy op_code 0..N_UNITS-1.
- `STACK_DEPTH` = 4: call-stack entries, ≥1.
- `TIMEOUT` = 24'd10_000_000: maximum EXEC cycles before the timeout error.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `run_mode` in 1: 1 = free-run, 0 = single-step.
- `step` in 1: one-cycle advance pulse, already debounced.
- `mem_addr` out PC_W: script ROM address, always equal to `pc`.
- `mem_data` in INSTR_W: ROM data, valid one cycle after `mem_addr`.
- `unit_start` out N_UNITS: one-hot, one-cycle start pulse.
- `unit_instr` out INSTR_W: current instruction, held from DISPATCH until the next LATCH.
- `unit_done` in N_UNITS: completion pulse/level from each unit.
- `unit_jump` in N_UNITS: sampled together with `unit_done`. 1 = take branch.
- `unit_target` in N_UNITS*PC_W: branch target of unit i at bits [i*PC_W +: PC_W].
- `pc` out PC_W: current instruction address.
- `state` out 3: FSM state encoding, for LEDs/debug.
- `halted` out 1: high in HALT.
- `error` out 3: 0 none, 1 illegal opcode, 2 stack overflow, 3 stack underflow, 4 timeout.
- `retired` out 16: count of completed instructions, wraps.

## Operation
FSM states: GATE(0), FETCH(1), LATCH(2), DISPATCH(3), EXEC(4), HALT(5), ERROR(6).
- GATE → FETCH when `run_mode`=1, or when `step`=1. Otherwise hold. `step` is ignored in every other state.
- FETCH: ROM addressed with `pc`. Unconditionally → LATCH.
- LATCH: IR ← `mem_data`. → DISPATCH.
- DISPATCH decodes op_code:
  - op < N_UNITS: `unit_start[op]` ← 1 for this cycle only; timeout counter cleared; → EXEC.
  - op = 7, func 00 (nop): pc ← pc+PC_STEP; retired+1; → GATE.
  - op = 7, func 01 (call): if stack full → ERROR code 2. Else push pc+PC_STEP; pc ← i_num[PC_W-1:0]; retired+1; → GATE.
  - op = 7, func 10 (return): if stack empty → ERROR code 3. Else pc ← pop; retired+1; → GATE.
  - op = 7, func 11 (halt): → HALT; pc unchanged.
  - Any other op: → ERROR code 1.
- EXEC: watch only `unit_done[op]`; other units' done bits are ignored.
  - On done: pc ← `unit_jump[op]` ? `unit_target[op]` : pc+PC_STEP; retired+1; → GATE.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no done → ERROR code 4.
  - Done on the same cycle as the timeout wins (completes normally).
- HALT, ERROR: terminal. Only `rst` exits. Outputs hold. `unit_start` stays 0.
- Arithmetic: pc+PC_STEP is modulo 2^PC_W (wraps to low addresses). Stack pointer range 0..STACK_DEPTH.
- A `run_mode` change takes effect at the next GATE. An instruction in flight always completes.

## Timing
- Reset values: `pc`=0, `mem_addr`=0, `unit_start`=0, `unit_instr`=0, `state`=GATE, `halted`=0, `error`=0, `retired`=0. Stack pointer = 0 (empty).
- `rst` asserted mid-EXEC: immediate return to reset values. The unit already started is not aborted by this block.
- All outputs are registered, except `mem_addr` (= pc register).
- Free-run internal instruction: 4 cycles (GATE, FETCH, LATCH, DISPATCH).
- Free-run unit instruction: 4 + k cycles, where done is first seen k ≥ 1 cycles after the start pulse.
- `unit_start` is asserted in the DISPATCH cycle. `unit_done` is not sampled before the following cycle.
- The new pc is visible on `mem_addr` in the GATE cycle after completion.

## Test plan
- Reset, run_mode=1, ROM: 0x0007 (nop) ×3 then 0x001F (halt) → pc steps 0,2,4,6; at pc=6 `halted`=1, `retired`=3, `error`=0; nop spacing is 4 cycles.
- run_mode=0, op0 instruction, unit 0 done 3 cycles after start → exactly one `unit_start[0]` pulse per `step` pulse; pc 0→2; idles in GATE without `step`.
- Unit 1 instruction, done with `unit_jump[1]`=1, target 0x40 → pc=0x40 next GATE. Repeat at pc=0xFE with no jump → pc wraps to 0x00.
- Call 0x0A0F (call 0x0A) from pc=4 → pc=0x0A; return 0x0017 → pc=6. Five nested calls with STACK_DEPTH=4 → `error`=2. Return on empty stack → `error`=3.
- TIMEOUT=16, unit never signals done → `error`=4 after 16 EXEC cycles. Op code 6 with N_UNITS=4 → `error`=1. Assert `rst` mid-EXEC → all outputs return to reset values asynchronously.
